// File: rtl/sub_sub_add_pkg.sv
// Shared constants and helpers for the pipelined c - a - b datapath.
// Imported by the lane unit and the pipeline top.
package sub_sub_add_pkg;

    localparam logic SSA_MODE_WRAP = 1'b0;
    localparam logic SSA_MODE_SAT  = 1'b1;

    // Two extra bits hold c - a - b exactly: range is -(2^(W+1)-2) .. 2^W-1
    function automatic int ssa_ext_w(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/sub_sub_add_lane.sv
// One lane of c - a - b on zero-extended operands.
// Wraps modulo 2^W or clamps negatives to zero.
module sub_sub_add_lane
    import sub_sub_add_pkg::*;
#(
    parameter int W = 8,
    localparam int XW = ssa_ext_w(W)
) (
    input  logic [XW-1:0] a,
    input  logic [XW-1:0] b,
    input  logic [XW-1:0] c,
    input  logic          mode,
    output logic [W-1:0]  result,
    output logic          clip
);

    logic signed [XW-1:0] exact;

    assign exact  = c - a - b;
    assign clip   = exact[XW-1];
    assign result = (mode == SSA_MODE_SAT && clip) ? '0
                                                    : exact[W-1:0];

endmodule

// File: rtl/sub_sub_add_pipe.sv
// Two-stage, multi-lane c - a - b with wrap/saturate mode and a
// shared valid/ready handshake; full throughput under backpressure.
module sub_sub_add_pipe
    import sub_sub_add_pkg::*;
#(
    parameter int W     = 8,
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*LANES-1:0] num1,
    input  logic [W*LANES-1:0] num2,
    input  logic [W*LANES-1:0] num3,
    input  logic               sat_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*LANES-1:0] result,
    output logic [LANES-1:0]   clip
);

    localparam int XW = ssa_ext_w(W);

    logic                      s1_v;
    logic [LANES-1:0][XW-1:0]  s1_a;
    logic [LANES-1:0][XW-1:0]  s1_b;
    logic [LANES-1:0][XW-1:0]  s1_c;
    logic                      s1_mode;

    logic [W*LANES-1:0]        lane_res;
    logic [LANES-1:0]          lane_clip;

    logic in_acc;
    logic s1_adv;
    logic s2_adv;

    assign in_ready = !s1_v || !out_valid || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign s1_adv   = s1_v && (!out_valid || out_ready);
    assign s2_adv   = out_valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sub_sub_add_lane #(.W(W)) u_lane (
            .a      (s1_a[i]),
            .b      (s1_b[i]),
            .c      (s1_c[i]),
            .mode   (s1_mode),
            .result (lane_res[i*W +: W]),
            .clip   (lane_clip[i])
        );
    end

    // Data registers only load on a handshake so idle lanes do not toggle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c      <= '0;
            s1_mode   <= SSA_MODE_WRAP;
            out_valid <= 1'b0;
            result    <= '0;
            clip      <= '0;
        end else begin
            if (in_acc) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_a[i] <= XW'(num1[i*W +: W]);
                    s1_b[i] <= XW'(num2[i*W +: W]);
                    s1_c[i] <= XW'(num3[i*W +: W]);
                end
                s1_mode <= sat_mode;
                s1_v    <= 1'b1;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            if (s1_adv) begin
                out_valid <= 1'b1;
                result    <= lane_res;
                clip      <= lane_clip;
            end else if (s2_adv) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
